// File: rtl/game_score_keeper.sv
// Per-game score engine: start-score load, per-second decay, saturating
// bonus/penalty events, final-score latch on game over and session high score.
module game_score_keeper #(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned SEC_W       = 16,
    parameter int unsigned START_SCORE = 32'h0000_FFFF,
    parameter int unsigned DECAY       = 65,
    parameter int unsigned EVT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               gameover,
    input  logic               bonus_valid,
    input  logic [EVT_W-1:0]   bonus_amt,
    input  logic               penalty_valid,
    input  logic [EVT_W-1:0]   penalty_amt,
    output logic [SCORE_W-1:0] score,
    output logic [SEC_W-1:0]   seconds,
    output logic [SCORE_W-1:0] final_score,
    output logic               final_valid,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic [1:0]         state
);

    localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned SUM_W = SCORE_W + 2;

    localparam logic [PRE_W-1:0]        PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
    localparam logic [SCORE_W-1:0]      START_VAL = SCORE_W'(START_SCORE);
    localparam logic signed [SUM_W-1:0] DECAY_S   = SUM_W'(DECAY);
    localparam logic signed [SUM_W-1:0] SCORE_MAX = $signed({2'b00, {SCORE_W{1'b1}}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t              cur_state;
    state_t              next_state;
    logic [PRE_W-1:0]    prescaler;
    logic [PRE_W-1:0]    prescaler_n;
    logic [SCORE_W-1:0]  score_n;
    logic [SEC_W-1:0]    seconds_n;
    logic [SCORE_W-1:0]  final_score_n;
    logic                final_valid_n;
    logic [SCORE_W-1:0]  high_score_n;
    logic                new_high_n;
    logic                tick;
    logic signed [SUM_W-1:0] sum;
    logic [SCORE_W-1:0]  score_upd;

    assign state = cur_state;

    // Second tick and saturating score arithmetic in a widened signed domain
    always_comb begin
        tick = (cur_state == ST_RUN) && (prescaler == PRE_LAST);
        sum  = $signed({2'b00, score})
             + (bonus_valid   ? $signed({{(SUM_W-EVT_W){1'b0}}, bonus_amt})   : '0)
             - (tick          ? DECAY_S                                       : '0)
             - (penalty_valid ? $signed({{(SUM_W-EVT_W){1'b0}}, penalty_amt}) : '0);
        if (sum < 0) begin
            score_upd = '0;
        end else if (sum > SCORE_MAX) begin
            score_upd = '1;
        end else begin
            score_upd = sum[SCORE_W-1:0];
        end
    end

    // Next-state and next-register values; gameover takes priority over events
    always_comb begin
        next_state    = cur_state;
        prescaler_n   = prescaler;
        score_n       = score;
        seconds_n     = seconds;
        final_score_n = final_score;
        final_valid_n = 1'b0;
        high_score_n  = high_score;
        new_high_n    = 1'b0;
        case (cur_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    next_state  = ST_RUN;
                    score_n     = START_VAL;
                    seconds_n   = '0;
                    prescaler_n = '0;
                end
            end
            ST_RUN: begin
                if (gameover) begin
                    next_state    = ST_OVER;
                    prescaler_n   = '0;
                    final_score_n = score;
                    final_valid_n = 1'b1;
                    if (score > high_score) begin
                        high_score_n = score;
                        new_high_n   = 1'b1;
                    end
                end else begin
                    score_n = score_upd;
                    if (tick) begin
                        prescaler_n = '0;
                        if (seconds != '1) begin
                            seconds_n = seconds + SEC_W'(1);
                        end
                    end else begin
                        prescaler_n = prescaler + PRE_W'(1);
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            score       <= '0;
            seconds     <= '0;
            final_score <= '0;
            final_valid <= 1'b0;
            high_score  <= '0;
            new_high    <= 1'b0;
        end else begin
            prescaler   <= prescaler_n;
            score       <= score_n;
            seconds     <= seconds_n;
            final_score <= final_score_n;
            final_valid <= final_valid_n;
            high_score  <= high_score_n;
            new_high    <= new_high_n;
        end
    end

endmodule

// File: tb/tb_game_score_keeper.sv
// Scoreboard bench for game_score_keeper with a short game second.
module tb_game_score_keeper;

    localparam int unsigned TICK  = 4;
    localparam int unsigned SW    = 16;
    localparam int unsigned SECW  = 16;
    localparam int unsigned START = 32'h0000_FFFF;
    localparam int unsigned DEC   = 65;
    localparam int unsigned EW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          gameover;
    logic          bonus_valid;
    logic [EW-1:0] bonus_amt;
    logic          penalty_valid;
    logic [EW-1:0] penalty_amt;
    logic [SW-1:0] score;
    logic [SECW-1:0] seconds;
    logic [SW-1:0] final_score;
    logic          final_valid;
    logic [SW-1:0] high_score;
    logic          new_high;
    logic [1:0]    state;

    game_score_keeper #(
        .TICK_CYCLES(TICK), .SCORE_W(SW), .SEC_W(SECW),
        .START_SCORE(START), .DECAY(DEC), .EVT_W(EW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .gameover(gameover),
        .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
        .penalty_valid(penalty_valid), .penalty_amt(penalty_amt),
        .score(score), .seconds(seconds), .final_score(final_score),
        .final_valid(final_valid), .high_score(high_score),
        .new_high(new_high), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] fs;
        logic          nh;
        logic [SW-1:0] hs;
    } fin_t;

    fin_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model of the score engine
    int m_score = 0;
    int m_pre   = 0;
    int m_sec   = 0;
    int m_state = 0;
    int m_high  = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare live outputs
    task automatic step(input logic s, input logic g, input logic bv, input int ba,
                        input logic pv, input int pa);
        fin_t f;
        int   v;
        logic tk;
        start = s; gameover = g;
        bonus_valid = bv; bonus_amt = EW'(ba);
        penalty_valid = pv; penalty_amt = EW'(pa);
        if (m_state != 1) begin
            if (s) begin
                m_state = 1; m_score = START; m_sec = 0; m_pre = 0;
            end
        end else if (g) begin
            f.fs = SW'(m_score);
            f.nh = (m_score > m_high);
            if (m_score > m_high) m_high = m_score;
            f.hs = SW'(m_high);
            exp_q.push_back(f);
            m_state = 2; m_pre = 0;
        end else begin
            tk = (m_pre == int'(TICK) - 1);
            v  = m_score + (bv ? ba : 0) - (tk ? int'(DEC) : 0) - (pv ? pa : 0);
            if (v < 0) v = 0;
            if (v > 65535) v = 65535;
            m_score = v;
            if (tk) begin
                m_pre = 0;
                if (m_sec < 65535) m_sec++;
            end else begin
                m_pre++;
            end
        end
        @(negedge clk);
        start = 1'b0; gameover = 1'b0; bonus_valid = 1'b0; penalty_valid = 1'b0;
        bonus_amt = '0; penalty_amt = '0;
        chk("score", score, m_score);
        chk("state", state, m_state);
        chk("seconds", seconds, m_sec);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Steer the running score to a target with bounded event traffic
    task automatic drive_to(input int target);
        int need;
        for (int i = 0; i < 1000 && m_score != target; i++) begin
            need = m_score - target - ((m_pre == int'(TICK) - 1) ? int'(DEC) : 0);
            if (need > 255)     step(0, 0, 0, 0, 1, 255);
            else if (need > 0)  step(0, 0, 0, 0, 1, need);
            else if (need < 0)  step(0, 0, 1, (-need > 255) ? 255 : -need, 0, 0);
            else                idle(1);
        end
        chk("drive_to", score, target);
    endtask

    task automatic idle_to_tick();
        for (int i = 0; i < int'(TICK) && m_pre != int'(TICK) - 1; i++) idle(1);
    endtask

    // Monitor: every final_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        fin_t e;
        if (!reset) begin
            if (final_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL final_valid_unexpected actual=1 required=0 final_score=%0d", final_score);
                end else begin
                    e = exp_q.pop_front();
                    chk("final_score", final_score, e.fs);
                    chk("new_high", new_high, e.nh);
                    chk("high_score", high_score, e.hs);
                end
            end else if (new_high) begin
                checks++; failures++;
                $display("FAIL new_high_alone actual=1 required=0");
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; gameover = 1'b0;
        bonus_valid = 1'b0; bonus_amt = '0; penalty_valid = 1'b0; penalty_amt = '0;
        repeat (2) @(negedge clk);
        chk("rst_score", score, 0);
        chk("rst_state", state, 0);
        chk("rst_seconds", seconds, 0);
        chk("rst_final", final_score, 0);
        chk("rst_high", high_score, 0);
        chk("rst_pulses", {final_valid, new_high}, 0);
        reset = 1'b0;

        // Decay: ticks on the 4th, 8th and 12th running cycle
        step(1, 0, 0, 0, 0, 0);
        chk("start_score", score, 16'hFFFF);
        idle(3);
        chk("pre_tick", score, 16'hFFFF);
        idle(1);
        chk("first_tick", score, 16'hFFBE);
        idle(8);
        chk("decay12", score, 16'hFF3C);
        chk("sec3", seconds, 3);

        // Upper clamp
        step(0, 0, 1, 200, 0, 0);
        chk("clamp_hi", score, 16'hFFFF);

        // Simultaneous tick, bonus and penalty with the full-scale score
        idle(2);
        step(0, 0, 1, 10, 1, 3);
        chk("combo_top", score, 16'hFFC5);

        // Same-cycle terms from 1000
        drive_to(1000);
        idle_to_tick();
        step(0, 0, 1, 10, 1, 3);
        chk("combo_942", score, 942);

        // Lower clamp and stays at zero through ticks
        drive_to(100);
        idle_to_tick();
        step(0, 0, 0, 0, 1, 50);
        chk("clamp_lo", score, 0);
        idle(8);
        chk("stay_zero", score, 0);
        chk("still_run", state, 1);

        // Game 1 ends at 500: new high
        drive_to(500);
        step(0, 1, 0, 0, 0, 0);
        chk("over_state", state, 2);
        step(0, 0, 1, 100, 1, 20);
        chk("over_hold", score, 500);
        step(0, 1, 0, 0, 0, 0);
        idle(2);

        // Game 2 ties at 500; game 3 ends lower at 400
        step(1, 0, 0, 0, 0, 0);
        drive_to(500);
        step(0, 1, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0);
        drive_to(400);
        step(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("high_kept", high_score, 500);

        // start in RUN ignored; start+gameover together ends the game
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        chk("start_ignored", score, 16'hFFBE);
        chk("start_ign_sec", seconds, 1);
        step(1, 1, 0, 0, 0, 0);
        chk("both_over", state, 2);
        idle(2);

        // Asynchronous reset between edges, then restart
        step(1, 0, 0, 0, 0, 0);
        idle(3);
        #2 reset = 1'b1;
        #1;
        chk("arst_score", score, 0);
        chk("arst_state", state, 0);
        chk("arst_high", high_score, 0);
        chk("arst_final", final_score, 0);
        m_score = 0; m_pre = 0; m_sec = 0; m_state = 0; m_high = 0;
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        chk("restart", score, 16'hFFFF);
        step(0, 1, 0, 0, 0, 0);
        idle(3);

        chk("pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
